intersection_controller: RTL
============================

INTERSECTION_CONTROLLER -- requirements
Module: intersection_controller

Interface
REQ-001 SHALL have parameter GREEN_MIN, default 4, minimum green cycles for either road (>=1).
REQ-002 SHALL have parameter GREEN_MAX, default 8, maximum side-road green cycles (>=GREEN_MIN).
REQ-003 SHALL have parameter YELLOW_T, default 2, yellow duration in cycles (>=1).
REQ-004 SHALL have parameter ALLRED_T, default 1, all-red clearance in cycles (>=1).
REQ-005 SHALL have parameter WALK_T, default 3, pedestrian walk duration in cycles (>=1).
REQ-006 SHALL have parameter CNT_W, default 8, timer width; every duration SHALL fit in CNT_W bits.
REQ-007 SHALL have port clk  input  1  single clock; all logic on the rising edge.
REQ-008 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-009 SHALL have port side_req  input  1  side-road vehicle sensor, level.
REQ-010 SHALL have port ped_req  input  1  pedestrian button, pulse or level.
REQ-011 SHALL have port main_lights  output  3  {red,yellow,green} for the main road.
REQ-012 SHALL have port side_lights  output  3  {red,yellow,green} for the side road.
REQ-013 SHALL have port walk  output  1  pedestrian walk signal.
REQ-014 SHALL have port ped_ack  output  1  one-cycle pulse when a walk phase starts.
REQ-015 SHALL have port phase  output  3  current state encoding, for observability.

Function
REQ-016 SHALL implement states MAIN_GREEN=0, MAIN_YELLOW=1, ALL_RED_A=2, SIDE_GREEN=3, SIDE_YELLOW=4, ALL_RED_B=5, PED_WALK=6; encoding 7 unreachable and SHALL recover to MAIN_GREEN.
REQ-017 SHALL encode lights one-hot: green 3'b001, yellow 3'b010, red 3'b100; each road output SHALL be exactly one-hot in every cycle.
REQ-018 SHALL drive main green only in MAIN_GREEN, main yellow only in MAIN_YELLOW, and main red otherwise; side road likewise for SIDE_GREEN/SIDE_YELLOW.
REQ-019 SHALL assert walk only in PED_WALK, with both roads red.
REQ-020 SHALL register all outputs; outputs SHALL reflect the state held during that cycle.
REQ-021 SHALL load a down-counter with (duration-1) on every state entry, so that each state's dwell time equals its duration; "timer done" means counter==0.
REQ-022 SHALL latch side_pending when side_req=1 in any state other than SIDE_GREEN, and SHALL clear it on entry to SIDE_GREEN.
REQ-023 SHALL latch ped_pending when ped_req=1 in any state other than PED_WALK, and SHALL clear it on entry to PED_WALK; ped_req coinciding with that entry is absorbed by the walk that is starting.
REQ-024 SHALL remain in MAIN_GREEN until timer done AND (side_pending OR ped_pending); with no requests it SHALL hold indefinitely.
REQ-025 SHALL transition MAIN_YELLOW->ALL_RED_A, SIDE_YELLOW->ALL_RED_B, and ALL_RED_B->MAIN_GREEN when the timer is done.
REQ-026 SHALL transition from ALL_RED_A on timer done to PED_WALK if ped_pending, otherwise to SIDE_GREEN.
REQ-027 SHALL transition from PED_WALK on timer done to SIDE_GREEN if side_pending, otherwise to ALL_RED_B.
REQ-028 SHALL leave SIDE_GREEN for SIDE_YELLOW after GREEN_MIN cycles if side_req=0, and SHALL extend while side_req=1 up to a total of GREEN_MAX cycles.
REQ-029 SHALL pulse ped_ack for exactly the first cycle of PED_WALK.

Reset
REQ-030 SHALL, while reset_n=0, force state MAIN_GREEN, timer=GREEN_MIN-1, main_lights=3'b001, side_lights=3'b100, walk=0, ped_ack=0, phase=0, and both pending flags=0, asynchronously and independent of clk.
REQ-031 SHALL, on reset assertion mid-operation, abandon the current phase and clear pending requests.

Structure
REQ-032 SHALL place the state enumeration and the light encoding constants in the shared package intersection_pkg.
REQ-033 SHALL instantiate one sub-module, phase_timer (loadable CNT_W down-counter with done flag).

Verification (GREEN_MIN=4, GREEN_MAX=8, YELLOW_T=2, ALLRED_T=1, WALK_T=3)
REQ-034 SHALL check: reset release with no requests for 100 cycles -> main_lights=001, side_lights=100, and phase=0 throughout.
REQ-035 SHALL check: one-cycle side_req pulse 1 cycle after reset -> main green 4, yellow 2, all-red 1, side green 4, side yellow 2, all-red 1, then MAIN_GREEN.
REQ-036 SHALL check: side_req held high -> side green lasts exactly 8 cycles, then SIDE_YELLOW.
REQ-037 SHALL check: ped_req pulse only -> after ALL_RED_A, ped_ack=1 for 1 cycle, walk=1 for 3 cycles with both roads 100, then ALL_RED_B 1 cycle, then MAIN_GREEN.
REQ-038 SHALL check: ped_req and side_req together -> walk of 3 cycles precedes side green; a ped_req on the cycle of walk entry produces no second walk.
REQ-039 SHALL check: reset_n dropped mid SIDE_GREEN -> outputs take their reset values before the next clock edge, and no pending request is served after release.

Source files
------------

// File: rtl/intersection_pkg.sv
// Shared definitions for the intersection controller.
// Holds the phase enumeration, which is also the encoding seen on the
// phase output, and the one-hot light codes used for both roads.
package intersection_pkg;

    typedef enum logic [2:0] {
        MAIN_GREEN  = 3'd0,
        MAIN_YELLOW = 3'd1,
        ALL_RED_A   = 3'd2,
        SIDE_GREEN  = 3'd3,
        SIDE_YELLOW = 3'd4,
        ALL_RED_B   = 3'd5,
        PED_WALK    = 3'd6
    } phase_t;

    // Light codes, packed as {red,yellow,green}
    localparam logic [2:0] LIGHT_GREEN  = 3'b001;
    localparam logic [2:0] LIGHT_YELLOW = 3'b010;
    localparam logic [2:0] LIGHT_RED    = 3'b100;

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter that times how long each phase lasts.
// Ports:
//   clk      - rising-edge clock
//   reset_n  - asynchronous active-low reset, returns the count to RESET_VAL
//   i_load   - load i_value this cycle (takes priority over counting)
//   i_value  - value to load, which is the phase duration minus one
//   o_count  - current count
//   o_done   - high while the count is zero
module phase_timer #(
    parameter int              CNT_W     = 8,
    parameter logic [CNT_W-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_value,
    output logic [CNT_W-1:0] o_count,
    output logic             o_done
);

    logic [CNT_W-1:0] r_count;

    // The counter parks at zero so a phase that waits on an external
    // request keeps reporting done until it is allowed to move on.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= RESET_VAL;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_count = r_count;
    assign o_done  = (r_count == '0);

endmodule

// File: rtl/intersection_controller.sv
// Traffic controller for a main road, a side road and a pedestrian crossing.
// Main road rests on green; side-road and pedestrian requests are latched
// and served in turn, with yellow and all-red clearance between phases.
// Ports:
//   clk          - rising-edge clock
//   reset_n      - asynchronous active-low reset
//   side_req     - side-road vehicle sensor (level)
//   ped_req      - pedestrian button (pulse or level)
//   main_lights  - {red,yellow,green} for the main road
//   side_lights  - {red,yellow,green} for the side road
//   walk         - pedestrian walk signal
//   ped_ack      - single-cycle pulse on the first walk cycle
//   phase        - current phase encoding
module intersection_controller
    import intersection_pkg::*;
#(
    parameter int GREEN_MIN = 4,
    parameter int GREEN_MAX = 8,
    parameter int YELLOW_T  = 2,
    parameter int ALLRED_T  = 1,
    parameter int WALK_T    = 3,
    parameter int CNT_W     = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       side_req,
    input  logic       ped_req,
    output logic [2:0] main_lights,
    output logic [2:0] side_lights,
    output logic       walk,
    output logic       ped_ack,
    output logic [2:0] phase
);

    // Side green may end early once the count has fallen to this value,
    // i.e. once GREEN_MIN cycles have elapsed from the GREEN_MAX-1 load.
    localparam logic [CNT_W-1:0] SIDE_EXT = CNT_W'(GREEN_MAX - GREEN_MIN);

    phase_t           r_state;
    phase_t           w_next;
    logic             r_side_pending;
    logic             r_ped_pending;
    logic [2:0]       r_main_lights;
    logic [2:0]       r_side_lights;
    logic             r_walk;
    logic             r_ped_ack;
    logic [CNT_W-1:0] w_count;
    logic             w_done;
    logic             w_load;
    logic [CNT_W-1:0] w_load_value;
    logic [2:0]       w_main_next;
    logic [2:0]       w_side_next;

    // Phase sequencing. Any phase change restarts the timer with the
    // duration of the phase being entered.
    always_comb begin
        w_next = r_state;
        case (r_state)
            MAIN_GREEN:  if (w_done && (r_side_pending || r_ped_pending)) w_next = MAIN_YELLOW;
            MAIN_YELLOW: if (w_done) w_next = ALL_RED_A;
            ALL_RED_A:   if (w_done) w_next = r_ped_pending ? PED_WALK : SIDE_GREEN;
            SIDE_GREEN:  if (w_done || (!side_req && (w_count <= SIDE_EXT))) w_next = SIDE_YELLOW;
            SIDE_YELLOW: if (w_done) w_next = ALL_RED_B;
            ALL_RED_B:   if (w_done) w_next = MAIN_GREEN;
            PED_WALK:    if (w_done) w_next = r_side_pending ? SIDE_GREEN : ALL_RED_B;
            default:     w_next = MAIN_GREEN;
        endcase
    end

    // Timer reload value and light pattern for the phase about to be held.
    // Side green loads its maximum; the early exit above trims it.
    always_comb begin
        w_load       = (w_next != r_state);
        w_load_value = CNT_W'(GREEN_MIN - 1);
        w_main_next  = LIGHT_RED;
        w_side_next  = LIGHT_RED;
        case (w_next)
            MAIN_GREEN:  begin w_load_value = CNT_W'(GREEN_MIN - 1); w_main_next = LIGHT_GREEN;  end
            MAIN_YELLOW: begin w_load_value = CNT_W'(YELLOW_T - 1);  w_main_next = LIGHT_YELLOW; end
            ALL_RED_A:   w_load_value = CNT_W'(ALLRED_T - 1);
            SIDE_GREEN:  begin w_load_value = CNT_W'(GREEN_MAX - 1); w_side_next = LIGHT_GREEN;  end
            SIDE_YELLOW: begin w_load_value = CNT_W'(YELLOW_T - 1);  w_side_next = LIGHT_YELLOW; end
            ALL_RED_B:   w_load_value = CNT_W'(ALLRED_T - 1);
            PED_WALK:    w_load_value = CNT_W'(WALK_T - 1);
            default:     w_load_value = CNT_W'(GREEN_MIN - 1);
        endcase
    end

    phase_timer #(
        .CNT_W     (CNT_W),
        .RESET_VAL (CNT_W'(GREEN_MIN - 1))
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .i_load  (w_load),
        .i_value (w_load_value),
        .o_count (w_count),
        .o_done  (w_done)
    );

    // State and outputs are registered together from the next-state
    // decode, so the outputs always describe the phase currently held.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= MAIN_GREEN;
            r_main_lights <= LIGHT_GREEN;
            r_side_lights <= LIGHT_RED;
            r_walk        <= 1'b0;
            r_ped_ack     <= 1'b0;
        end else begin
            r_state       <= w_next;
            r_main_lights <= w_main_next;
            r_side_lights <= w_side_next;
            r_walk        <= (w_next == PED_WALK);
            r_ped_ack     <= (w_next == PED_WALK) && (r_state != PED_WALK);
        end
    end

    // Request latches. Clearing on entry wins over a request arriving on
    // the same edge, so that request is treated as served by the new phase.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_side_pending <= 1'b0;
            r_ped_pending  <= 1'b0;
        end else begin
            if (w_next == SIDE_GREEN && r_state != SIDE_GREEN) begin
                r_side_pending <= 1'b0;
            end else if (side_req && r_state != SIDE_GREEN) begin
                r_side_pending <= 1'b1;
            end
            if (w_next == PED_WALK && r_state != PED_WALK) begin
                r_ped_pending <= 1'b0;
            end else if (ped_req && r_state != PED_WALK) begin
                r_ped_pending <= 1'b1;
            end
        end
    end

    assign main_lights = r_main_lights;
    assign side_lights = r_side_lights;
    assign walk        = r_walk;
    assign ped_ack     = r_ped_ack;
    assign phase       = r_state;

endmodule
